// File: rtl/octavo_io_port_endpoint.sv
// Octavo I/O port endpoint: bridges an external valid/ready input stream
// into the Datapath read port (EF/rden) and the Datapath write port
// (EF/wren) back out to an external valid/ready output stream. Each
// direction has its own circular FIFO; every output comes from registered
// state only.
module octavo_io_port_endpoint #(
  parameter int WORD_WIDTH  = 36,
  parameter int DEPTH       = 4,
  parameter int DEPTH_WIDTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   io_read_EF,
  output logic [WORD_WIDTH-1:0]  io_read_data,
  input  logic                   io_rden,
  output logic                   io_write_EF,
  input  logic [WORD_WIDTH-1:0]  io_write_data,
  input  logic                   io_wren,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DEPTH_WIDTH:0]   read_count,
  output logic [DEPTH_WIDTH:0]   write_count,
  input  logic                   error_clear,
  output logic                   read_underrun,
  output logic                   write_overrun
);

  localparam logic [DEPTH_WIDTH:0]   CNT_FULL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   CNT_ZERO = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

  // Read FIFO state (external producer -> Datapath)
  logic [WORD_WIDTH-1:0]  rd_mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] rd_rptr_q, rd_rptr_d, rd_wptr_q, rd_wptr_d;
  logic [DEPTH_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic                   rd_push_s, rd_pop_s, underrun_q, underrun_d;

  // Write FIFO state (Datapath -> external consumer)
  logic [WORD_WIDTH-1:0]  wr_mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_rptr_q, wr_rptr_d, wr_wptr_q, wr_wptr_d;
  logic [DEPTH_WIDTH:0]   wr_cnt_q, wr_cnt_d;
  logic                   wr_push_s, wr_pop_s, overrun_q, overrun_d;

  // Handshake qualification; all decisions use the pre-edge registered counts
  always_comb begin
    rd_push_s = in_valid  & (rd_cnt_q != CNT_FULL);
    rd_pop_s  = io_rden   & (rd_cnt_q != CNT_ZERO);
    wr_push_s = io_wren   & (wr_cnt_q != CNT_FULL);
    wr_pop_s  = out_ready & (wr_cnt_q != CNT_ZERO);
  end

  // Read FIFO next-state: pointers advance modulo DEPTH, count tracks push/pop
  always_comb begin
    rd_wptr_d = rd_push_s ? rd_wptr_q + PTR_ONE : rd_wptr_q;
    rd_rptr_d = rd_pop_s  ? rd_rptr_q + PTR_ONE : rd_rptr_q;
    case ({rd_push_s, rd_pop_s})
      2'b10:   rd_cnt_d = rd_cnt_q + CNT_ONE;
      2'b01:   rd_cnt_d = rd_cnt_q - CNT_ONE;
      default: rd_cnt_d = rd_cnt_q;
    endcase
  end

  // Write FIFO next-state: same structure as the read side
  always_comb begin
    wr_wptr_d = wr_push_s ? wr_wptr_q + PTR_ONE : wr_wptr_q;
    wr_rptr_d = wr_pop_s  ? wr_rptr_q + PTR_ONE : wr_rptr_q;
    case ({wr_push_s, wr_pop_s})
      2'b10:   wr_cnt_d = wr_cnt_q + CNT_ONE;
      2'b01:   wr_cnt_d = wr_cnt_q - CNT_ONE;
      default: wr_cnt_d = wr_cnt_q;
    endcase
  end

  // Sticky error flags: a new error in the same cycle as a clear wins
  always_comb begin
    if (io_rden && (rd_cnt_q == CNT_ZERO)) begin
      underrun_d = 1'b1;
    end else if (error_clear) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
    if (io_wren && (wr_cnt_q == CNT_FULL)) begin
      overrun_d = 1'b1;
    end else if (error_clear) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers; storage is cleared on reset so heads read back as zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i] <= '0;
        wr_mem_q[i] <= '0;
      end
      rd_rptr_q  <= '0;
      rd_wptr_q  <= '0;
      rd_cnt_q   <= '0;
      wr_rptr_q  <= '0;
      wr_wptr_q  <= '0;
      wr_cnt_q   <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (rd_push_s) begin
        rd_mem_q[rd_wptr_q] <= in_data;
      end
      if (wr_push_s) begin
        wr_mem_q[wr_wptr_q] <= io_write_data;
      end
      rd_rptr_q  <= rd_rptr_d;
      rd_wptr_q  <= rd_wptr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_rptr_q  <= wr_rptr_d;
      wr_wptr_q  <= wr_wptr_d;
      wr_cnt_q   <= wr_cnt_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  // Outputs decode registered state only (no input-to-output paths)
  always_comb begin
    in_ready      = (rd_cnt_q != CNT_FULL);
    io_read_EF    = (rd_cnt_q != CNT_ZERO);
    io_read_data  = rd_mem_q[rd_rptr_q];
    io_write_EF   = (wr_cnt_q != CNT_FULL);
    out_valid     = (wr_cnt_q != CNT_ZERO);
    out_data      = wr_mem_q[wr_rptr_q];
    read_count    = rd_cnt_q;
    write_count   = wr_cnt_q;
    read_underrun = underrun_q;
    write_overrun = overrun_q;
  end

endmodule

// File: tb/tb_octavo_io_port_endpoint.sv
// Self-checking bench for octavo_io_port_endpoint: a queue per direction
// holds expected words, pushed when a handshake is driven and popped when
// the DUT delivers the head word; counts and flags follow a small model.
module tb_octavo_io_port_endpoint;

  localparam int W = 36;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data, io_read_data, io_write_data, out_data;
  logic         in_valid, in_ready, io_read_EF, io_rden;
  logic         io_write_EF, io_wren, out_valid, out_ready;
  logic [2:0]   read_count, write_count;
  logic         error_clear, read_underrun, write_overrun;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rd_sb[$];
  logic [W-1:0] wr_sb[$];
  int           rcnt_m = 0;
  int           wcnt_m = 0;
  logic         rerr_m = 1'b0;
  logic         werr_m = 1'b0;

  octavo_io_port_endpoint #(.WORD_WIDTH(W), .DEPTH(4), .DEPTH_WIDTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .io_read_EF(io_read_EF), .io_read_data(io_read_data), .io_rden(io_rden),
    .io_write_EF(io_write_EF), .io_write_data(io_write_data), .io_wren(io_wren),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .read_count(read_count), .write_count(write_count),
    .error_clear(error_clear), .read_underrun(read_underrun),
    .write_overrun(write_overrun)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare every observable output against the model
  task automatic check_status();
    check_eq("read_count",    64'(read_count),  64'(rcnt_m));
    check_eq("write_count",   64'(write_count), 64'(wcnt_m));
    check_eq("in_ready",      64'(in_ready),    64'(rcnt_m != 4));
    check_eq("io_read_EF",    64'(io_read_EF),  64'(rcnt_m != 0));
    check_eq("io_write_EF",   64'(io_write_EF), 64'(wcnt_m != 4));
    check_eq("out_valid",     64'(out_valid),   64'(wcnt_m != 0));
    check_eq("read_underrun", 64'(read_underrun), 64'(rerr_m));
    check_eq("write_overrun", 64'(write_overrun), 64'(werr_m));
    if (rcnt_m != 0) check_eq("rd_head_now", 64'(io_read_data), 64'(rd_sb[0]));
    if (wcnt_m != 0) check_eq("wr_head_now", 64'(out_data),     64'(wr_sb[0]));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge counts
  task automatic cyc(input logic iv, input logic [W-1:0] id, input logic rden,
                     input logic wren, input logic [W-1:0] wd,
                     input logic ordy, input logic eclr);
    logic rpush, rpop, wpush, wpop;
    logic [W-1:0] exp;
    in_valid = iv; in_data = id; io_rden = rden;
    io_wren = wren; io_write_data = wd; out_ready = ordy; error_clear = eclr;
    rpush = iv   && (rcnt_m != 4);
    rpop  = rden && (rcnt_m != 0);
    wpush = wren && (wcnt_m != 4);
    wpop  = ordy && (wcnt_m != 0);
    if (rpop) begin
      exp = rd_sb.pop_front();
      check_eq("rd_pop_data", 64'(io_read_data), 64'(exp));
    end
    if (wpop) begin
      exp = wr_sb.pop_front();
      check_eq("wr_pop_data", 64'(out_data), 64'(exp));
    end
    if (rpush) rd_sb.push_back(id);
    if (wpush) wr_sb.push_back(wd);
    rerr_m = (rden && rcnt_m == 0) ? 1'b1 : (eclr ? 1'b0 : rerr_m);
    werr_m = (wren && wcnt_m == 4) ? 1'b1 : (eclr ? 1'b0 : werr_m);
    rcnt_m = rcnt_m + int'(rpush) - int'(rpop);
    wcnt_m = wcnt_m + int'(wpush) - int'(wpop);
    tick();
    check_status();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"},  64'(in_ready),      64'd1);
    check_eq({tag, "_rd_EF"},     64'(io_read_EF),    64'd0);
    check_eq({tag, "_rd_data"},   64'(io_read_data),  64'd0);
    check_eq({tag, "_wr_EF"},     64'(io_write_EF),   64'd1);
    check_eq({tag, "_out_valid"}, 64'(out_valid),     64'd0);
    check_eq({tag, "_out_data"},  64'(out_data),      64'd0);
    check_eq({tag, "_rcnt"},      64'(read_count),    64'd0);
    check_eq({tag, "_wcnt"},      64'(write_count),   64'd0);
    check_eq({tag, "_uerr"},      64'(read_underrun), 64'd0);
    check_eq({tag, "_oerr"},      64'(write_overrun), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; io_rden = 1'b0; io_wren = 1'b0;
    io_write_data = '0; out_ready = 1'b0; error_clear = 1'b0;
    tick();
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    idle();

    // Fill and drain the read FIFO
    for (int i = 1; i <= 4; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("fill_in_ready", 64'(in_ready), 64'd0);
    check_eq("fill_rcnt",     64'(read_count), 64'd4);
    cyc(1'b1, 36'h5, 1'b0, 1'b0, '0, 1'b0, 1'b0);  // refused while full
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_order", 64'(io_read_data), 64'(i));
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    end
    check_eq("drain_EF", 64'(io_read_EF), 64'd0);

    // Underrun while a word is pushed on the same edge
    cyc(1'b1, 36'h7, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("under_flag", 64'(read_underrun), 64'd1);
    check_eq("under_rcnt", 64'(read_count), 64'd1);
    check_eq("under_data", 64'(io_read_data), 64'h7);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("under_clear", 64'(read_underrun), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Set and clear in the same cycle: set wins
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check_eq("set_wins", 64'(read_underrun), 64'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Pointer wrap with continuous write streaming
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0, 1'b0, 1'b1, W'(36'hA0 + i), 1'b1, 1'b0);
      check_eq("wrap_cnt_le1", 64'(write_count <= 3'd1), 64'd1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("wrap_sb_empty", 64'(wr_sb.size()), 64'd0);
    check_eq("wrap_no_overrun", 64'(write_overrun), 64'd0);

    // Back-pressure then one-per-cycle drain
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, W'(36'hB0 + i), 1'b0, 1'b0);
    check_eq("bp_wr_EF", 64'(io_write_EF), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_out_data", 64'(out_data), 64'(36'hB0 + i));
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("bp_out_valid", 64'(out_valid), 64'd0);

    // Write FIFO full: pop happens, pushed word dropped, overrun set
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, W'(36'hC0 + i), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 36'h55, 1'b1, 1'b0);
    check_eq("full_overrun", 64'(write_overrun), 64'd1);
    check_eq("full_wcnt",    64'(write_count), 64'd3);
    check_eq("full_head",    64'(out_data), 64'hC1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("full_no_55", 64'(write_count), 64'd0);

    // Reset asserted mid-operation with two words in each FIFO
    for (int i = 0; i < 2; i++) cyc(1'b1, W'(36'hD0 + i), 1'b0, 1'b1, W'(36'hE0 + i), 1'b0, 1'b0);
    idle();
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rd_sb.delete(); wr_sb.delete();
    rcnt_m = 0; wcnt_m = 0; rerr_m = 1'b0; werr_m = 1'b0;
    tick();
    check_reset_outputs("rsthold");
    reset_n = 1'b1;
    idle();
    cyc(1'b1, 36'h9, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("post_rst_head", 64'(io_read_data), 64'h9);
    check_eq("post_rst_rcnt", 64'(read_count), 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
